// File: rtl/tcm_arb_pkg.sv
// Shared types for the TCM port arbiter: master identifiers and master count.
package tcm_arb_pkg;

  typedef enum logic {
    MST_CORE = 1'b0,
    MST_DBG  = 1'b1
  } mst_id_e;

  localparam int unsigned NumMasters = 2;

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order owner-tracking FIFO: records which master issued each accepted
// request so the matching response can be routed back to it.
module arb_owner_fifo
  import tcm_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  mst_id_e push_id,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output mst_id_e head
);

  // A single-entry FIFO still needs a one-bit pointer to index storage.
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  mst_id_e           mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; push and pop together leave count as is.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= MST_CORE;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= push_id;
    end
  end

`ifndef SYNTHESIS
  no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);
  no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);
`endif

endmodule

// File: rtl/tcm_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-port TCM slave. A
// request stalled by the slave is locked until accepted, and responses are
// steered back to their issuing master through an in-order owner FIFO.
module tcm_port_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int unsigned   AW             = 32,
  parameter int unsigned   DW             = 32,
  parameter int unsigned   MaxOutstanding = 2,
  parameter logic [AW-1:0] SlaveBase      = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  // Core data master
  input  logic            m0_req,
  output logic            m0_gnt,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_be,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  // Debug master
  input  logic            m1_req,
  output logic            m1_gnt,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_be,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  // Slave port
  output logic            s_req,
  input  logic            s_gnt,
  output logic            s_we,
  output logic [DW/8-1:0] s_be,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  input  logic            s_rvalid,
  input  logic [DW-1:0]   s_rdata,
  output logic            err_unexp_o
);

  mst_id_e rr_ptr_q, rr_ptr_d;
  logic    lock_q, lock_d;
  mst_id_e locked_id_q, locked_id_d;
  logic    err_unexp_q, err_unexp_d;

  mst_id_e         sel;
  logic            sel_req;
  logic            sel_we;
  logic [DW/8-1:0] sel_be;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  logic    handshake;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fifo_pop;
  mst_id_e fifo_head;

  // Master selection: a locked request wins, then a sole requester, then rr_ptr.
  always_comb begin
    sel = rr_ptr_q;
    if (lock_q) begin
      sel = locked_id_q;
    end else if (m0_req && !m1_req) begin
      sel = MST_CORE;
    end else if (m1_req && !m0_req) begin
      sel = MST_DBG;
    end
  end

  // Payload mux from the selected master.
  always_comb begin
    sel_req   = m0_req;
    sel_we    = m0_we;
    sel_be    = m0_be;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (sel == MST_DBG) begin
      sel_req   = m1_req;
      sel_we    = m1_we;
      sel_be    = m1_be;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  // Slave-side outputs. A full FIFO blocks the request using the registered
  // count only, so a same-cycle response never feeds back into s_req.
  // Outputs are forced low while reset is asserted.
  always_comb begin
    s_req   = rst_n & sel_req & ~fifo_full;
    s_we    = rst_n & sel_we;
    s_be    = rst_n ? sel_be : '0;
    s_addr  = rst_n ? (sel_addr - SlaveBase) : '0;
    s_wdata = rst_n ? sel_wdata : '0;
  end

  assign handshake = s_req & s_gnt;
  assign m0_gnt    = handshake & (sel == MST_CORE);
  assign m1_gnt    = handshake & (sel == MST_DBG);

  // Response routing: the FIFO head names the owner of the returning beat.
  always_comb begin
    fifo_pop  = s_rvalid & ~fifo_empty;
    m0_rvalid = fifo_pop & (fifo_head == MST_CORE);
    m1_rvalid = fifo_pop & (fifo_head == MST_DBG);
    m0_rdata  = rst_n ? s_rdata : '0;
    m1_rdata  = rst_n ? s_rdata : '0;
  end

  // Round-robin pointer, request lock and sticky error next-state.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    err_unexp_d = err_unexp_q | (s_rvalid & fifo_empty);
    if (handshake) begin
      rr_ptr_d = (sel == MST_CORE) ? MST_DBG : MST_CORE;
      lock_d   = 1'b0;
    end else if (s_req) begin
      lock_d      = 1'b1;
      locked_id_d = sel;
    end else if (lock_q && !sel_req) begin
      // Locked master abandoned its request; release so the other can proceed.
      lock_d = 1'b0;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= MST_CORE;
      lock_q      <= 1'b0;
      locked_id_q <= MST_CORE;
      err_unexp_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  assign err_unexp_o = err_unexp_q;

  arb_owner_fifo #(
    .Depth (MaxOutstanding)
  ) u_owner_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (handshake),
    .push_id (sel),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

`ifndef SYNTHESIS
  rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(m0_rvalid && m1_rvalid));
  gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(m0_gnt && m1_gnt));
  lock_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    lock_q |-> ((locked_id_q == MST_CORE) ? m0_req : m1_req));
`endif

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Directed bench for tcm_port_arbiter: inputs change 1 time unit after the
// rising edge and outputs are compared 1 unit later, well before the next edge.
module tb_tcm_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            rst_n;
  logic            m0_req, m0_gnt, m0_we, m0_rvalid;
  logic [DW/8-1:0] m0_be;
  logic [AW-1:0]   m0_addr;
  logic [DW-1:0]   m0_wdata, m0_rdata;
  logic            m1_req, m1_gnt, m1_we, m1_rvalid;
  logic [DW/8-1:0] m1_be;
  logic [AW-1:0]   m1_addr;
  logic [DW-1:0]   m1_wdata, m1_rdata;
  logic            s_req, s_gnt, s_we, s_rvalid;
  logic [DW/8-1:0] s_be;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata, s_rdata;
  logic            err_unexp_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  tcm_port_arbiter #(
    .AW             (AW),
    .DW             (DW),
    .MaxOutstanding (2),
    .SlaveBase      (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req      (m0_req),
    .m0_gnt      (m0_gnt),
    .m0_we       (m0_we),
    .m0_be       (m0_be),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_rvalid   (m0_rvalid),
    .m0_rdata    (m0_rdata),
    .m1_req      (m1_req),
    .m1_gnt      (m1_gnt),
    .m1_we       (m1_we),
    .m1_be       (m1_be),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_rvalid   (m1_rvalid),
    .m1_rdata    (m1_rdata),
    .s_req       (s_req),
    .s_gnt       (s_gnt),
    .s_we        (s_we),
    .s_be        (s_be),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_rvalid    (s_rvalid),
    .s_rdata     (s_rdata),
    .err_unexp_o (err_unexp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_be = 4'hf; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'hf; m1_addr = '0; m1_wdata = '0;
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    check("rst_s_req", s_req, 1'b0);
    check("rst_gnts", {m0_gnt, m1_gnt}, 2'b00);
    check("rst_err", err_unexp_o, 1'b0);
    do_reset();

    // 1: single master, back-to-back reads, response one cycle later.
    m0_req = 1'b1; m0_addr = 32'h10; s_gnt = 1'b1;
    #1;
    check("t1_gnt_a", m0_gnt, 1'b1);
    check("t1_addr_a", s_addr, 32'h10);
    check("t1_nrv_a", m0_rvalid, 1'b0);
    tick();
    m0_addr = 32'h14; s_rvalid = 1'b1; s_rdata = 32'hA0;
    #1;
    check("t1_gnt_b", m0_gnt, 1'b1);
    check("t1_addr_b", s_addr, 32'h14);
    check("t1_rv_b", {m0_rvalid, m1_rvalid}, 2'b10);
    check("t1_rdata_b", m0_rdata, 32'hA0);
    tick();
    m0_req = 1'b0; s_rdata = 32'hA4;
    #1;
    check("t1_rv_c", {m0_rvalid, m1_rvalid}, 2'b10);
    check("t1_rdata_c", m0_rdata, 32'hA4);
    check("t1_err_c", err_unexp_o, 1'b0);
    tick();
    s_rvalid = 1'b0;

    // 2: both masters request continuously; grants alternate, responses routed.
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h100; m1_req = 1'b1; m1_addr = 32'h200; s_gnt = 1'b1;
    #1;
    check("t2_gnt_1", {m0_gnt, m1_gnt}, 2'b10);
    check("t2_addr_1", s_addr, 32'h100);
    tick();
    s_rvalid = 1'b1; s_rdata = 32'h11;
    #1;
    check("t2_gnt_2", {m0_gnt, m1_gnt}, 2'b01);
    check("t2_addr_2", s_addr, 32'h200);
    check("t2_rv_2", {m0_rvalid, m1_rvalid}, 2'b10);
    tick();
    s_rdata = 32'h22;
    #1;
    check("t2_gnt_3", {m0_gnt, m1_gnt}, 2'b10);
    check("t2_rv_3", {m0_rvalid, m1_rvalid}, 2'b01);
    check("t2_rdata_3", m1_rdata, 32'h22);
    tick();
    m0_req = 1'b0; m1_req = 1'b0; s_rdata = 32'h33;
    #1;
    check("t2_gnt_4", {m0_gnt, m1_gnt}, 2'b00);
    check("t2_rv_4", {m0_rvalid, m1_rvalid}, 2'b10);
    tick();
    s_rvalid = 1'b0;
    #1;
    check("t2_err", err_unexp_o, 1'b0);

    // 3: slave stalls three cycles with m0 selected; lock holds the selection.
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h100; m1_req = 1'b1; m1_addr = 32'h200; s_gnt = 1'b0;
    #1;
    check("t3_sreq_1", s_req, 1'b1);
    check("t3_addr_1", s_addr, 32'h100);
    tick();
    m1_req = 1'b0;
    #1;
    check("t3_addr_2", s_addr, 32'h100);
    check("t3_gnt_2", {m0_gnt, m1_gnt}, 2'b00);
    tick();
    m1_req = 1'b1;
    #1;
    check("t3_addr_3", s_addr, 32'h100);
    tick();
    s_gnt = 1'b1;
    #1;
    check("t3_gnt_4", {m0_gnt, m1_gnt}, 2'b10);
    tick();
    #1;
    check("t3_gnt_5", {m0_gnt, m1_gnt}, 2'b01);
    check("t3_addr_5", s_addr, 32'h200);
    tick();

    // 5: stray response with an empty FIFO sets the sticky error.
    do_reset();
    s_rvalid = 1'b1; s_rdata = 32'hDEAD;
    #1;
    check("t5_rv", {m0_rvalid, m1_rvalid}, 2'b00);
    tick();
    s_rvalid = 1'b0;
    #1;
    check("t5_err_set", err_unexp_o, 1'b1);
    tick();
    #1;
    check("t5_err_sticky", err_unexp_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_err_clr", err_unexp_o, 1'b0);

    // 4: two outstanding fill the FIFO; a pop unblocks only on the next cycle.
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h40; s_gnt = 1'b1;
    #1;
    check("t4_gnt_1", m0_gnt, 1'b1);
    tick();
    #1;
    check("t4_gnt_2", m0_gnt, 1'b1);
    tick();
    #1;
    check("t4_sreq_full", s_req, 1'b0);
    check("t4_gnt_full", m0_gnt, 1'b0);
    tick();
    s_rvalid = 1'b1; s_rdata = 32'h55;
    #1;
    check("t4_sreq_pop", s_req, 1'b0);
    check("t4_rv_pop", m0_rvalid, 1'b1);
    tick();
    s_rvalid = 1'b0;
    #1;
    check("t4_sreq_next", s_req, 1'b1);
    check("t4_gnt_next", m0_gnt, 1'b1);
    tick();

    // 6: asynchronous reset with two outstanding; state fully cleared.
    m1_req = 1'b1; m1_addr = 32'h200;
    rst_n = 1'b0;
    #1;
    check("t6_async_sreq", s_req, 1'b0);
    check("t6_async_gnt", {m0_gnt, m1_gnt}, 2'b00);
    check("t6_async_addr", s_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("t6_first_gnt", {m0_gnt, m1_gnt}, 2'b10);
    tick();
    m0_req = 1'b0; m1_req = 1'b0; s_rvalid = 1'b1;
    #1;
    check("t6_rv_first", {m0_rvalid, m1_rvalid}, 2'b10);
    tick();
    #1;
    check("t6_err_after_one", err_unexp_o, 1'b0);
    tick();
    s_rvalid = 1'b0;
    #1;
    check("t6_stale_err", err_unexp_o, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
